// File: rtl/pc_unit.sv
// Fetch-stage program counter with next-PC selection (increment, relative branch,
// absolute jump) and call/return through a small LIFO return-address stack.
module pc_unit #(
  parameter int ADDR_WIDTH   = 12,
  parameter int RESET_VECTOR = 0,
  parameter int STEP         = 1,
  parameter int RAS_DEPTH    = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [2:0]                       op,
  input  logic                             cond,
  input  logic [ADDR_WIDTH-1:0]            target,
  input  logic [ADDR_WIDTH-1:0]            offset,
  output logic [ADDR_WIDTH-1:0]            pc_out,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_depth,
  output logic                             ras_overflow,
  output logic                             ras_underflow
);

  localparam int DEPTH_W = $clog2(RAS_DEPTH + 1);
  localparam int IDX_W   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  localparam logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(RESET_VECTOR);
  localparam logic [ADDR_WIDTH-1:0] STEP_V   = ADDR_WIDTH'(STEP);
  localparam logic [DEPTH_W-1:0]    FULL     = DEPTH_W'(RAS_DEPTH);

  typedef enum logic [2:0] {
    OP_INC    = 3'd0,
    OP_BRANCH = 3'd1,
    OP_JUMP   = 3'd2,
    OP_CALL   = 3'd3,
    OP_RET    = 3'd4,
    OP_HOLD   = 3'd5
  } op_e;

  logic [ADDR_WIDTH-1:0] ras_mem [RAS_DEPTH];

  logic [ADDR_WIDTH-1:0] seq;
  logic [ADDR_WIDTH-1:0] ras_top;
  logic [IDX_W-1:0]      push_idx;
  logic [IDX_W-1:0]      pop_idx;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic [DEPTH_W-1:0]    depth_next;
  logic                  overflow_next;
  logic                  underflow_next;
  logic                  push;

  assign seq      = pc_out + STEP_V;
  assign push_idx = IDX_W'(ras_depth);
  assign pop_idx  = IDX_W'(ras_depth - 1'b1);
  assign ras_top  = ras_mem[pop_idx];

  // Reserved op codes fall through to the default and behave as HOLD.
  always_comb begin
    pc_next        = pc_out;
    depth_next     = ras_depth;
    overflow_next  = ras_overflow;
    underflow_next = ras_underflow;
    push           = 1'b0;
    if (enable) begin
      case (op)
        OP_INC:    pc_next = seq;
        OP_BRANCH: pc_next = cond ? (pc_out + offset) : seq;
        OP_JUMP:   pc_next = target;
        OP_CALL: begin
          pc_next = target;
          if (ras_depth == FULL) begin
            overflow_next = 1'b1;
          end else begin
            push       = 1'b1;
            depth_next = ras_depth + 1'b1;
          end
        end
        OP_RET: begin
          if (ras_depth == '0) begin
            pc_next        = seq;
            underflow_next = 1'b1;
          end else begin
            pc_next    = ras_top;
            depth_next = ras_depth - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_out        <= RESET_PC;
      ras_depth     <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      pc_out        <= pc_next;
      ras_depth     <= depth_next;
      ras_overflow  <= overflow_next;
      ras_underflow <= underflow_next;
    end
  end

  // Stack storage has no reset; entries above ras_depth are never read.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      ras_mem[push_idx] <= seq;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: directed ops push hand-computed expectations,
// a monitor pops and compares one entry after each clock edge.
module tb_pc_unit;

  localparam logic [2:0] INC  = 3'd0;
  localparam logic [2:0] BRA  = 3'd1;
  localparam logic [2:0] JMP  = 3'd2;
  localparam logic [2:0] CALL = 3'd3;
  localparam logic [2:0] RET  = 3'd4;
  localparam logic [2:0] HOLD = 3'd5;
  localparam logic [2:0] RSV  = 3'd7;

  typedef struct {
    logic [11:0] pc;
    logic [2:0]  depth;
    logic        ovf;
    logic        unf;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [2:0]  op;
  logic        cond;
  logic [11:0] target;
  logic [11:0] offset;
  logic [11:0] pc_out;
  logic [2:0]  ras_depth;
  logic        ras_overflow;
  logic        ras_underflow;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  pc_unit #(
    .ADDR_WIDTH(12), .RESET_VECTOR(0), .STEP(1), .RAS_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .op(op), .cond(cond),
    .target(target), .offset(offset), .pc_out(pc_out), .ras_depth(ras_depth),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic e, input logic [2:0] o,
                               input logic c, input logic [11:0] t, input logic [11:0] off,
                               input logic [11:0] epc, input logic [2:0] ed,
                               input logic eo, input logic eu, input string nm);
    exp_t item;
    @(negedge clk);
    reset  = r;
    enable = e;
    op     = o;
    cond   = c;
    target = t;
    offset = off;
    item.pc    = epc;
    item.depth = ed;
    item.ovf   = eo;
    item.unf   = eu;
    item.name  = nm;
    exp_q.push_back(item);
  endtask

  task automatic checkOutput(input exp_t item);
    compared++;
    if (pc_out !== item.pc || ras_depth !== item.depth ||
        ras_overflow !== item.ovf || ras_underflow !== item.unf) begin
      mismatched++;
      $display("[TB] FAIL %s: got pc=%h depth=%0d ovf=%b unf=%b, expected pc=%h depth=%0d ovf=%b unf=%b",
               item.name, pc_out, ras_depth, ras_overflow, ras_underflow,
               item.pc, item.depth, item.ovf, item.unf);
    end
  endtask

  initial begin : monitor
    exp_t item;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        item = exp_q.pop_front();
        checkOutput(item);
      end
    end
  end

  initial begin : stimulus
    reset = 1'b1; enable = 1'b0; op = HOLD; cond = 1'b0; target = '0; offset = '0;

    //             rst   en    op    c     target   offset   pc       d     ovf   unf
    applyStimulus(1'b1, 1'b0, HOLD, 1'b0, 12'h000, 12'h000, 12'h000, 3'd0, 1'b0, 1'b0, "reset");
    applyStimulus(1'b0, 1'b1, INC,  1'b0, 12'h000, 12'h000, 12'h001, 3'd0, 1'b0, 1'b0, "inc1");
    applyStimulus(1'b0, 1'b1, INC,  1'b0, 12'h000, 12'h000, 12'h002, 3'd0, 1'b0, 1'b0, "inc2");
    applyStimulus(1'b0, 1'b1, INC,  1'b0, 12'h000, 12'h000, 12'h003, 3'd0, 1'b0, 1'b0, "inc3");

    applyStimulus(1'b0, 1'b1, JMP,  1'b0, 12'hFFE, 12'h000, 12'hFFE, 3'd0, 1'b0, 1'b0, "jump_ffe");
    applyStimulus(1'b0, 1'b1, INC,  1'b0, 12'h000, 12'h000, 12'hFFF, 3'd0, 1'b0, 1'b0, "inc_fff");
    applyStimulus(1'b0, 1'b1, INC,  1'b0, 12'h000, 12'h000, 12'h000, 3'd0, 1'b0, 1'b0, "inc_wrap");
    applyStimulus(1'b0, 1'b1, JMP,  1'b0, 12'h010, 12'h000, 12'h010, 3'd0, 1'b0, 1'b0, "jump_010");
    applyStimulus(1'b0, 1'b1, BRA,  1'b1, 12'h000, 12'hFFE, 12'h00E, 3'd0, 1'b0, 1'b0, "branch_taken_neg");
    applyStimulus(1'b0, 1'b1, BRA,  1'b0, 12'h000, 12'hFFE, 12'h00F, 3'd0, 1'b0, 1'b0, "branch_not_taken");
    applyStimulus(1'b0, 1'b1, BRA,  1'b1, 12'h000, 12'h011, 12'h020, 3'd0, 1'b0, 1'b0, "branch_taken_pos");

    applyStimulus(1'b0, 1'b1, JMP,  1'b0, 12'h100, 12'h000, 12'h100, 3'd0, 1'b0, 1'b0, "jump_100");
    applyStimulus(1'b0, 1'b1, CALL, 1'b0, 12'h200, 12'h000, 12'h200, 3'd1, 1'b0, 1'b0, "call_200");
    applyStimulus(1'b0, 1'b1, INC,  1'b0, 12'h000, 12'h000, 12'h201, 3'd1, 1'b0, 1'b0, "inc_in_call");
    applyStimulus(1'b0, 1'b1, RET,  1'b0, 12'h000, 12'h000, 12'h101, 3'd0, 1'b0, 1'b0, "ret_101");

    // Pushed return addresses are 0x001, 0x011, 0x021, 0x031; the fifth call is dropped.
    applyStimulus(1'b1, 1'b1, INC,  1'b0, 12'h000, 12'h000, 12'h000, 3'd0, 1'b0, 1'b0, "reset2");
    applyStimulus(1'b0, 1'b1, CALL, 1'b0, 12'h010, 12'h000, 12'h010, 3'd1, 1'b0, 1'b0, "call_10");
    applyStimulus(1'b0, 1'b1, CALL, 1'b0, 12'h020, 12'h000, 12'h020, 3'd2, 1'b0, 1'b0, "call_20");
    applyStimulus(1'b0, 1'b1, CALL, 1'b0, 12'h030, 12'h000, 12'h030, 3'd3, 1'b0, 1'b0, "call_30");
    applyStimulus(1'b0, 1'b1, CALL, 1'b0, 12'h040, 12'h000, 12'h040, 3'd4, 1'b0, 1'b0, "call_40");
    applyStimulus(1'b0, 1'b1, CALL, 1'b0, 12'h050, 12'h000, 12'h050, 3'd4, 1'b1, 1'b0, "call_50_full");
    applyStimulus(1'b0, 1'b1, RET,  1'b0, 12'h000, 12'h000, 12'h031, 3'd3, 1'b1, 1'b0, "ret_a");
    applyStimulus(1'b0, 1'b1, RET,  1'b0, 12'h000, 12'h000, 12'h021, 3'd2, 1'b1, 1'b0, "ret_b");
    applyStimulus(1'b0, 1'b1, RET,  1'b0, 12'h000, 12'h000, 12'h011, 3'd1, 1'b1, 1'b0, "ret_c");
    applyStimulus(1'b0, 1'b1, RET,  1'b0, 12'h000, 12'h000, 12'h001, 3'd0, 1'b1, 1'b0, "ret_d");

    applyStimulus(1'b0, 1'b1, JMP,  1'b0, 12'h055, 12'h000, 12'h055, 3'd0, 1'b1, 1'b0, "jump_055");
    applyStimulus(1'b0, 1'b1, RET,  1'b0, 12'h000, 12'h000, 12'h056, 3'd0, 1'b1, 1'b1, "ret_empty");
    applyStimulus(1'b0, 1'b1, INC,  1'b0, 12'h000, 12'h000, 12'h057, 3'd0, 1'b1, 1'b1, "unf_sticky1");
    applyStimulus(1'b0, 1'b1, INC,  1'b0, 12'h000, 12'h000, 12'h058, 3'd0, 1'b1, 1'b1, "unf_sticky2");

    applyStimulus(1'b0, 1'b0, JMP,  1'b0, 12'h3AA, 12'h000, 12'h058, 3'd0, 1'b1, 1'b1, "stall1");
    applyStimulus(1'b0, 1'b0, JMP,  1'b0, 12'h3AA, 12'h000, 12'h058, 3'd0, 1'b1, 1'b1, "stall2");
    applyStimulus(1'b0, 1'b0, CALL, 1'b0, 12'h3AA, 12'h000, 12'h058, 3'd0, 1'b1, 1'b1, "stall_call");
    applyStimulus(1'b0, 1'b1, HOLD, 1'b0, 12'h3AA, 12'h000, 12'h058, 3'd0, 1'b1, 1'b1, "hold_op");
    applyStimulus(1'b0, 1'b1, RSV,  1'b0, 12'h3AA, 12'h000, 12'h058, 3'd0, 1'b1, 1'b1, "reserved_op");

    applyStimulus(1'b1, 1'b1, CALL, 1'b0, 12'h3AA, 12'h000, 12'h000, 3'd0, 1'b0, 1'b0, "reset_vs_call");
    applyStimulus(1'b0, 1'b1, INC,  1'b0, 12'h000, 12'h000, 12'h001, 3'd0, 1'b0, 1'b0, "inc_after_reset");
    applyStimulus(1'b0, 1'b1, RET,  1'b0, 12'h000, 12'h000, 12'h002, 3'd0, 1'b0, 1'b1, "ret_no_push");

    @(negedge clk);
    enable = 1'b0;
    op     = HOLD;
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
